rx_bps_gen: RTL and testbench

Parametrised bit-timing generator for the serial receive path. It is the successor to the fixed 100-clock bit counter. It adds:
- a runtime-loadable divisor,
- separate mid-bit sample and bit-end strobes,
- a bit index within the frame,
- a frame-complete strobe.

It sits between the start-bit detector, which drives Count_Sig, and the rx shift/control logic, which consumes BPS_CLK, Bit_Idx and Frame_Done.

---
 rtl/rx_bps_gen_pkg.sv | 8 +
 rtl/rx_bps_gen_if.sv | 26 ++
 rtl/rx_bps_gen.sv | 92 +++++++++
 tb/tb_rx_bps_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_bps_gen_pkg.sv
// Shared constants for the receive bit-timing generator.
// Holds the divisor floor and the default frame geometry.
package rx_bps_pkg;
    localparam int DIV_MIN            = 2;
    localparam int DIV_RESET_DEFAULT  = 100;
    localparam int FRAME_BITS_DEFAULT = 10;
    localparam int CNT_W_DEFAULT      = 16;
endpackage

// File: rtl/rx_bps_gen_if.sv
// Control and strobe bundle between the start detector, the bit-timing generator and rx control.
// Inputs are level/pulse signals sampled on CLK; outputs are single-cycle strobes plus Bit_Idx/Busy levels.
interface rx_bps_gen_if #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 4
);
    logic             Count_Sig;
    logic [CNT_W-1:0] Div;
    logic             Div_Load;
    logic             BPS_CLK;
    logic             Bit_End;
    logic [IDX_W-1:0] Bit_Idx;
    logic             Frame_Done;
    logic             Busy;
    logic             Cfg_Err;

    modport master (
        output Count_Sig, Div, Div_Load,
        input  BPS_CLK, Bit_End, Bit_Idx, Frame_Done, Busy, Cfg_Err
    );

    modport slave (
        input  Count_Sig, Div, Div_Load,
        output BPS_CLK, Bit_End, Bit_Idx, Frame_Done, Busy, Cfg_Err
    );
endinterface

// File: rtl/rx_bps_gen.sv
// Bit-timing generator: times exactly one frame per Count_Sig assertion with a loadable divisor,
// producing mid-bit sample, bit-end and frame-done strobes decoded straight from registered state.
module rx_bps_gen
    import rx_bps_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int DIV_RESET  = DIV_RESET_DEFAULT,
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int IDX_W      = 4
) (
    input  logic         CLK,
    input  logic         RST,
    rx_bps_gen_if.slave  bus
);
    localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             halted_q, halted_d;
    logic             cfg_err_q, cfg_err_d;

    logic busy;
    logic mid_bit;
    logic bit_end;
    logic frame_done;

    // div_q >= 2 always holds, so the mid-bit point never underflows.
    assign busy       = bus.Count_Sig && !halted_q;
    assign mid_bit    = busy && (cnt_q == ((div_q >> 1) - ONE));
    assign bit_end    = busy && (cnt_q == (div_q - ONE));
    assign frame_done = bit_end && (idx_q == LAST_IDX);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        idx_d     = idx_q;
        halted_d  = halted_q;
        cfg_err_d = 1'b0;

        if (!bus.Count_Sig) begin
            cnt_d    = '0;
            idx_d    = '0;
            halted_d = 1'b0;
        end else if (bit_end) begin
            cnt_d = '0;
            if (frame_done) begin
                idx_d    = '0;
                halted_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (busy) begin
            cnt_d = cnt_q + ONE;
        end

        // A divisor change mid-frame would corrupt bit timing, so it is refused and flagged.
        if (bus.Div_Load) begin
            if (!busy && (bus.Div >= DIV_MIN_W)) begin
                div_d = bus.Div;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST_W;
            idx_q     <= '0;
            halted_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            halted_q  <= halted_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.BPS_CLK    = mid_bit;
    assign bus.Bit_End    = bit_end;
    assign bus.Bit_Idx    = idx_q;
    assign bus.Frame_Done = frame_done;
    assign bus.Busy       = busy;
    assign bus.Cfg_Err    = cfg_err_q;
endmodule

// File: tb/tb_rx_bps_gen.sv
// Self-checking bench for rx_bps_gen: expected strobe events are queued per frame and matched as they appear.
// Event word = {kind[31:30], bit index[29:26], clocks since frame start[25:0]}.
module tb_rx_bps_gen;
    localparam int CNT_W = 16;
    localparam int IDX_W = 4;
    localparam int FB    = 10;

    localparam logic [1:0] K_MID  = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic CLK;
    logic RST;

    rx_bps_gen_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    rx_bps_gen #(
        .CNT_W(CNT_W), .DIV_RESET(100), .FRAME_BITS(FB), .IDX_W(IDX_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc;
    int start_cyc;
    bit mon_en;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input logic [1:0] kind, input int bit_no, input int rel);
        logic [3:0]  b4;
        logic [25:0] r26;
        b4  = 4'(bit_no);
        r26 = 26'(rel);
        return {kind, b4, r26};
    endfunction

    task automatic pop_cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val({"extra_", tag}, obs, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, obs, e);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            if (bus.BPS_CLK)    pop_cmp("bps_clk",    ev(K_MID,  int'(bus.Bit_Idx), cyc - start_cyc));
            if (bus.Bit_End)    pop_cmp("bit_end",    ev(K_END,  int'(bus.Bit_Idx), cyc - start_cyc));
            if (bus.Frame_Done) pop_cmp("frame_done", ev(K_DONE, int'(bus.Bit_Idx), cyc - start_cyc));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_bits(input int div, input int first, input int last);
        for (int b = first; b <= last; b++) begin
            exp_q.push_back(ev(K_MID, b, b * div + div / 2 - 1));
            exp_q.push_back(ev(K_END, b, b * div + div - 1));
            if (b == FB - 1) exp_q.push_back(ev(K_DONE, b, b * div + div - 1));
        end
    endtask

    task automatic start_frame();
        bus.Count_Sig = 1'b1;
        start_cyc     = cyc;
    endtask

    task automatic load_div(input int d);
        bus.Div      = CNT_W'(d);
        bus.Div_Load = 1'b1;
        tick(1);
        bus.Div_Load = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        check_val({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_busy_after"}, 32'(bus.Busy), 32'd0);
        exp_q.delete();
        bus.Count_Sig = 1'b0;
        tick(2);
    endtask

    task automatic full_frame(input string tag, input int div, input int tail);
        start_frame();
        push_bits(div, 0, FB - 1);
        tick(div * FB + tail);
        end_frame(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        start_cyc     = 0;
        mon_en        = 1'b0;
        RST           = 1'b1;
        bus.Count_Sig = 1'b0;
        bus.Div       = '0;
        bus.Div_Load  = 1'b0;
        tick(3);

        check_val("rst_bps",   32'(bus.BPS_CLK),    32'd0);
        check_val("rst_end",   32'(bus.Bit_End),    32'd0);
        check_val("rst_idx",   32'(bus.Bit_Idx),    32'd0);
        check_val("rst_done",  32'(bus.Frame_Done), 32'd0);
        check_val("rst_busy",  32'(bus.Busy),       32'd0);
        check_val("rst_cfg",   32'(bus.Cfg_Err),    32'd0);
        RST    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // 1: default divisor, Count_Sig held well past the frame end
        full_frame("t1", 100, 100);

        // 2: runtime divisor 4
        load_div(4);
        check_val("t2_cfg_ok", 32'(bus.Cfg_Err), 32'd0);
        full_frame("t2", 4, 10);

        // 3: restore 100, reject Div=1 idle, reject Div=8 while busy
        load_div(100);
        check_val("t3_load100_ok", 32'(bus.Cfg_Err), 32'd0);
        load_div(1);
        check_val("t3_rej_idle_hi", 32'(bus.Cfg_Err), 32'd1);
        tick(1);
        check_val("t3_rej_idle_lo", 32'(bus.Cfg_Err), 32'd0);
        start_frame();
        push_bits(100, 0, FB - 1);
        tick(3 * 100 + 10);
        check_val("t3_busy_bit3", 32'(bus.Busy), 32'd1);
        check_val("t3_idx_bit3",  32'(bus.Bit_Idx), 32'd3);
        load_div(8);
        check_val("t3_rej_busy_hi", 32'(bus.Cfg_Err), 32'd1);
        tick(1);
        check_val("t3_rej_busy_lo", 32'(bus.Cfg_Err), 32'd0);
        tick(1000 + 5 - 312);
        end_frame("t3");

        // 4: abort at bit 5 cnt 30, then a full restart
        start_frame();
        push_bits(100, 0, 4);
        tick(5 * 100 + 30);
        check_val("t4_idx_bit5", 32'(bus.Bit_Idx), 32'd5);
        bus.Count_Sig = 1'b0;
        tick(1);
        check_val("t4_abort_idx",  32'(bus.Bit_Idx), 32'd0);
        check_val("t4_abort_busy", 32'(bus.Busy),    32'd0);
        check_val("t4_abort_q",    32'(exp_q.size()), 32'd0);
        full_frame("t4", 100, 5);

        // 5: reset mid-frame after loading Div=20; divisor must revert to 100
        load_div(20);
        start_frame();
        push_bits(20, 0, 6);
        tick(7 * 20 + 5);
        check_val("t5_idx_bit7", 32'(bus.Bit_Idx), 32'd7);
        RST           = 1'b1;
        bus.Count_Sig = 1'b0;
        tick(1);
        check_val("t5_rst_idx",  32'(bus.Bit_Idx),    32'd0);
        check_val("t5_rst_busy", 32'(bus.Busy),       32'd0);
        check_val("t5_rst_bps",  32'(bus.BPS_CLK),    32'd0);
        check_val("t5_rst_end",  32'(bus.Bit_End),    32'd0);
        check_val("t5_rst_done", 32'(bus.Frame_Done), 32'd0);
        check_val("t5_rst_cfg",  32'(bus.Cfg_Err),    32'd0);
        check_val("t5_rst_q",    32'(exp_q.size()),   32'd0);
        RST = 1'b0;
        tick(1);
        full_frame("t5", 100, 5);

        // 6: minimum divisors
        load_div(2);
        check_val("t6_div2_ok", 32'(bus.Cfg_Err), 32'd0);
        full_frame("t6a", 2, 5);
        load_div(3);
        check_val("t6_div3_ok", 32'(bus.Cfg_Err), 32'd0);
        full_frame("t6b", 3, 5);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
